// File: rtl/slap_sram_pkg.sv
// Shared types for the background/sprite tile SRAM arbiter: FSM states,
// plane-pair selects and requester identifiers.
package slap_sram_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_PULSE = 3'd2,
    WR_HOLD  = 3'd3,
    RD0      = 3'd4,
    RD1      = 3'd5
  } sram_state_t;

  localparam logic PAIR_LO = 1'b0;
  localparam logic PAIR_HI = 1'b1;

  typedef enum logic [1:0] {
    REQ_DL  = 2'd0,
    REQ_BG  = 2'd1,
    REQ_SPR = 2'd2
  } req_id_t;

endpackage

// File: rtl/slap_sram_dl_buffer.sv
// One-entry capture of ROM download bytes with a sticky overrun flag.
// An incoming byte is visible as pending in its own cycle so an idle arbiter can take it at once.
module slap_sram_dl_buffer #(
  parameter int AW = 17
) (
  input  logic          master_clk,
  input  logic          RST_N,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          pop,
  output logic          pend_valid,
  output logic [AW-1:0] pend_addr,
  output logic [7:0]    pend_data,
  output logic          dl_overrun
);

  logic          full;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;

  assign pend_valid = full | dl_wr;
  assign pend_addr  = full ? addr_q : dl_addr;
  assign pend_data  = full ? data_q : dl_data;

  always_ff @(posedge master_clk or negedge RST_N) begin
    if (!RST_N) begin
      full       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      dl_overrun <= 1'b0;
    end else if (full) begin
      if (dl_wr) dl_overrun <= 1'b1;
      if (pop)   full       <= 1'b0;
    end else if (dl_wr && !pop) begin
      // A byte popped in the same cycle it arrives bypasses the slot entirely.
      full   <= 1'b1;
      addr_q <= dl_addr;
      data_q <= dl_data;
    end
  end

endmodule

// File: rtl/slap_bg_sram_arbiter.sv
// Arbitrates the shared 16-bit tile SRAM between download writes, the bg
// fetcher and the sprite fetcher; each fetch returns 4 planes from two word reads.
module slap_bg_sram_arbiter
  import slap_sram_pkg::*;
#(
  parameter int AW         = 17,
  parameter int ACC_CYC    = 2,
  parameter int SPR_STARVE = 2
) (
  input  logic          master_clk,
  input  logic          RST_N,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_overrun,
  input  logic          bg_req,
  input  logic [14:0]   bg_addr,
  output logic          bg_ack,
  output logic          bg_valid,
  output logic [31:0]   bg_data,
  input  logic          spr_req,
  input  logic [14:0]   spr_addr,
  output logic          spr_ack,
  output logic          spr_valid,
  output logic [31:0]   spr_data,
  output logic [AW-1:0] SRAM_ADDR,
  inout  logic [15:0]   SRAM_DQ,
  output logic          SRAM_OE_N,
  output logic          SRAM_WE_N,
  output logic          SRAM_UB_N,
  output logic          SRAM_LB_N
);

  localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 1);
  localparam int SW = $clog2(SPR_STARVE + 2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(SPR_STARVE);

  sram_state_t   state;
  req_id_t       cur_req;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic [14:0]   cur_addr;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [15:0]   lo_word;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic [7:0]    pend_data;
  logic          pop;
  logic          dq_drive;
  logic [AW-1:0] rd_word;
  logic          spr_first;

  assign pop       = (state == IDLE) && pend_valid;
  assign spr_first = spr_req && (starve >= STARVE_LIM);

  slap_sram_dl_buffer #(.AW(AW)) u_dl_buffer (
    .master_clk (master_clk),
    .RST_N      (RST_N),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .pop        (pop),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .dl_overrun (dl_overrun)
  );

  assign SRAM_DQ = dq_drive ? {wr_data, wr_data} : 'z;

  // Strobes decode straight from the state register so an async reset releases the bus at once.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_drive  = 1'b0;
    rd_word   = '0;
    rd_word[14:0] = cur_addr;
    unique case (state)
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        SRAM_ADDR = {1'b0, wr_addr[AW-1:1]};
        SRAM_LB_N = wr_addr[0];
        SRAM_UB_N = ~wr_addr[0];
        SRAM_WE_N = (state != WR_PULSE);
        dq_drive  = 1'b1;
      end
      RD0, RD1: begin
        rd_word[15] = (state == RD1) ? PAIR_HI : PAIR_LO;
        SRAM_ADDR = rd_word;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge master_clk or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cur_req   <= REQ_DL;
      cnt       <= '0;
      starve    <= '0;
      cur_addr  <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      lo_word   <= '0;
      bg_ack    <= 1'b0;
      spr_ack   <= 1'b0;
      bg_valid  <= 1'b0;
      spr_valid <= 1'b0;
      bg_data   <= '0;
      spr_data  <= '0;
    end else begin
      bg_ack    <= 1'b0;
      spr_ack   <= 1'b0;
      bg_valid  <= 1'b0;
      spr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pend_valid) begin
            state   <= WR_SETUP;
            cur_req <= REQ_DL;
            wr_addr <= pend_addr;
            wr_data <= pend_data;
          end else if (spr_first || (spr_req && !bg_req)) begin
            state    <= RD0;
            cur_req  <= REQ_SPR;
            cur_addr <= spr_addr;
            spr_ack  <= 1'b1;
            starve   <= '0;
          end else if (bg_req) begin
            state    <= RD0;
            cur_req  <= REQ_BG;
            cur_addr <= bg_addr;
            bg_ack   <= 1'b1;
            if (!spr_req)          starve <= '0;
            else if (starve != '1) starve <= starve + 1'b1;
          end
        end
        WR_SETUP: begin
          state <= WR_PULSE;
          cnt   <= '0;
        end
        WR_PULSE: begin
          if (cnt == CNT_LAST) state <= WR_HOLD;
          else                 cnt   <= cnt + 1'b1;
        end
        WR_HOLD: state <= IDLE;
        RD0: begin
          if (cnt == CNT_LAST) begin
            lo_word <= SRAM_DQ;
            state   <= RD1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD1: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            if (cur_req == REQ_SPR) begin
              spr_valid <= 1'b1;
              spr_data  <= {SRAM_DQ, lo_word};
            end else begin
              bg_valid <= 1'b1;
              bg_data  <= {SRAM_DQ, lo_word};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slap_bg_sram_arbiter.sv
// Directed bench for the tile SRAM arbiter with a behavioural async SRAM model.
module tb_slap_bg_sram_arbiter;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          dl_overrun;
  logic          bg_req = 1'b0;
  logic [14:0]   bg_addr = '0;
  logic          bg_ack, bg_valid;
  logic [31:0]   bg_data;
  logic          spr_req = 1'b0;
  logic [14:0]   spr_addr = '0;
  logic          spr_ack, spr_valid;
  logic [31:0]   spr_data;
  logic [AW-1:0] sram_addr;
  tri0  [15:0]   sram_dq;
  logic          sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:(1<<AW)-1] = '{default: 16'h0000};
  int total = 0;
  int bad = 0;
  int viol = 0;

  always #5 clk = ~clk;

  slap_bg_sram_arbiter #(.AW(AW), .ACC_CYC(2), .SPR_STARVE(2)) dut (
    .master_clk (clk),
    .RST_N      (rst_n),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_overrun (dl_overrun),
    .bg_req     (bg_req),
    .bg_addr    (bg_addr),
    .bg_ack     (bg_ack),
    .bg_valid   (bg_valid),
    .bg_data    (bg_data),
    .spr_req    (spr_req),
    .spr_addr   (spr_addr),
    .spr_ack    (spr_ack),
    .spr_valid  (spr_valid),
    .spr_data   (spr_data),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ    (sram_dq),
    .SRAM_OE_N  (sram_oe_n),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n)
  );

  // SRAM model: reads drive the bus while OE is low; released bus is pulled to 0.
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr] : 'z;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[17'h00123] <= 16'hB2A1;
      mem[17'h08123] <= 16'hD4C3;
      mem[17'h04123] <= 16'hEEEE;
      mem[17'h00001] <= 16'h6655;
      mem[17'h08001] <= 16'h8877;
      mem[17'h00002] <= 16'h3344;
      mem[17'h08002] <= 16'h1122;
    end else if (!sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
    end
  end

  always @(negedge clk) if (!sram_oe_n && !sram_we_n) viol = viol + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bg_read(input logic [14:0] a, input logic [31:0] exp, input string tag);
    int n;
    bg_addr = a;
    bg_req  = 1'b1;
    n = 0;
    do begin tick; n++; end while (bg_ack !== 1'b1 && n < 20);
    chk({tag, "_ack"}, bg_ack, 1);
    chk({tag, "_rd0_addr"}, sram_addr, {2'b00, a});
    bg_req = 1'b0;
    n = 0;
    do begin tick; n++; end while (bg_valid !== 1'b1 && n < 20);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_data"}, bg_data, exp);
  endtask

  logic [1:0] order [6];
  int ng;
  int n;

  initial begin
    // Reset state
    repeat (3) tick;
    chk("rst_oe", sram_oe_n, 1);
    chk("rst_we", sram_we_n, 1);
    chk("rst_ub", sram_ub_n, 1);
    chk("rst_lb", sram_lb_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_released", sram_dq, 0);
    chk("rst_acks", {bg_ack, spr_ack, bg_valid, spr_valid}, 0);
    chk("rst_bg_data", bg_data, 0);
    chk("rst_spr_data", spr_data, 0);
    chk("rst_overrun", dl_overrun, 0);
    rst_n = 1'b1;
    tick;

    // Basic bg fetch
    bg_read(15'h0123, 32'hD4C3B2A1, "rd1");
    tick;
    chk("rd1_valid_pulse", bg_valid, 0);
    chk("rd1_data_hold", bg_data, 32'hD4C3B2A1);

    // Upper-lane download write to word 3
    dl_addr = 17'h00007; dl_data = 8'h5A; dl_wr = 1'b1;
    tick;
    dl_wr = 1'b0;
    chk("wr_setup_addr", sram_addr, 17'h00003);
    chk("wr_setup_lanes", {sram_ub_n, sram_lb_n}, 2'b01);
    chk("wr_setup_we", sram_we_n, 1);
    chk("wr_setup_dq", sram_dq, 16'h5A5A);
    tick; chk("wr_pulse0_we", sram_we_n, 0);
    tick; chk("wr_pulse1_we", sram_we_n, 0);
    tick; chk("wr_hold_we", sram_we_n, 1);
    chk("wr_hold_dq", sram_dq, 16'h5A5A);
    tick; chk("wr_exit_dq", sram_dq, 0);
    chk("wr_mem3", mem[17'h00003], 16'h5A00);
    bg_read(15'h0003, 32'h00005A00, "rb3");

    // Two download bytes during a bg read: second dropped
    bg_addr = 15'h0123; bg_req = 1'b1;
    tick;
    chk("ov_ack", bg_ack, 1);
    bg_req = 1'b0;
    dl_addr = 17'h00010; dl_data = 8'h11; dl_wr = 1'b1;
    tick;
    chk("ov_first_ok", dl_overrun, 0);
    dl_addr = 17'h00011; dl_data = 8'h22;
    tick;
    dl_wr = 1'b0;
    chk("ov_set", dl_overrun, 1);
    chk("ov_no_preempt", {sram_oe_n, sram_we_n}, 2'b01);
    tick; chk("ov_valid_early", bg_valid, 0);
    tick; chk("ov_valid", bg_valid, 1);
    chk("ov_data", bg_data, 32'hD4C3B2A1);
    tick;
    chk("ov_wr_addr", sram_addr, 17'h00008);
    chk("ov_wr_lanes", {sram_ub_n, sram_lb_n}, 2'b10);
    chk("ov_wr_dq", sram_dq, 16'h1111);
    repeat (4) tick;
    chk("ov_mem8", mem[17'h00008], 16'h0011);
    chk("ov_sticky", dl_overrun, 1);

    // Starvation guard: bg, bg, spr, bg, bg, spr
    bg_addr = 15'h0001; spr_addr = 15'h0002;
    bg_req = 1'b1; spr_req = 1'b1;
    ng = 0;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      tick;
      if (bg_ack) begin order[ng] = 2'd1; ng++; end
      else if (spr_ack) begin order[ng] = 2'd2; ng++; end
    end
    bg_req = 1'b0; spr_req = 1'b0;
    chk("st_count", ng, 6);
    chk("st_g0", order[0], 1);
    chk("st_g1", order[1], 1);
    chk("st_g2", order[2], 2);
    chk("st_g3", order[3], 1);
    chk("st_g4", order[4], 1);
    chk("st_g5", order[5], 2);
    repeat (8) tick;
    chk("st_bg_data", bg_data, 32'h88776655);
    chk("st_spr_data", spr_data, 32'h11223344);

    // bg_req and dl_wr together from IDLE: write goes first
    bg_addr = 15'h0003; bg_req = 1'b1;
    dl_addr = 17'h00006; dl_data = 8'h77; dl_wr = 1'b1;
    tick;
    dl_wr = 1'b0;
    chk("sim_setup_addr", sram_addr, 17'h00003);
    chk("sim_setup_lanes", {sram_ub_n, sram_lb_n}, 2'b10);
    chk("sim_setup_noack", bg_ack, 0);
    tick; tick;
    tick;
    chk("sim_hold_we", sram_we_n, 1);
    chk("sim_hold_noack", bg_ack, 0);
    tick;
    chk("sim_idle_noack", bg_ack, 0);
    chk("sim_idle_oe", sram_oe_n, 1);
    tick;
    chk("sim_ack", bg_ack, 1);
    chk("sim_rd_addr", sram_addr, 17'h00003);
    bg_req = 1'b0;
    n = 0;
    do begin tick; n++; end while (bg_valid !== 1'b1 && n < 20);
    chk("sim_latency", n, 4);
    chk("sim_data", bg_data, 32'h00005A77);

    // Reset asserted during RD1
    bg_addr = 15'h0123; bg_req = 1'b1;
    tick;
    chk("rr_ack", bg_ack, 1);
    bg_req = 1'b0;
    tick; tick;
    chk("rr_rd1_oe", sram_oe_n, 0);
    chk("rr_rd1_addr", sram_addr, 17'h08123);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_strobes", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 4'hF);
    chk("rr_addr", sram_addr, 0);
    chk("rr_overrun", dl_overrun, 0);
    chk("rr_data", bg_data, 0);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rr_novalid_rst", bg_valid, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_novalid_after", bg_valid, 0);
    end

    chk("oe_we_overlap", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
